// File: rtl/pattern_sched_pkg.sv
// Shared types and constants for the pattern-core scheduler: FSM state encoding,
// default geometry, and the index-width helper used for requester IDs.
package pattern_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_IN_W     = 11;
    localparam int DEF_OUT_W    = 11;
    localparam int DEF_CORE_LAT = 2;

    // A requester index needs at least one bit, even with a single requester.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: zero latency, grants the first requester at or
// after i_ptr (cyclic); no backpressure of its own, the caller decides when a grant counts.
module rr_arbiter
    import pattern_sched_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    // Scan from the farthest candidate back to i_ptr so the nearest set bit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_core_scheduler.sv
// Time-shares one pattern core among NUM_REQ requesters: accept-to-response CORE_LAT edges,
// one transaction in flight; rsp_ready low parks the result in RESP and blocks new grants.
module pattern_core_scheduler
    import pattern_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int CORE_LAT = DEF_CORE_LAT
) (
    input  logic                        blif_clk_net,
    input  logic                        blif_reset_net,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IN_W-1:0]     req_vec,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [OUT_W-1:0]            rsp_data,
    output logic [idx_w(NUM_REQ)-1:0]   rsp_id,
    output logic [IN_W-1:0]             core_in,
    input  logic [OUT_W-1:0]            core_out,
    output logic                        busy,
    output logic [15:0]                 txn_count
);

    localparam int ID_W  = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(CORE_LAT + 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [IN_W-1:0]  r_core_in;
    logic [OUT_W-1:0] r_rsp_data;
    logic [ID_W-1:0]  r_rsp_id;
    logic [15:0]      r_txn_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic [IN_W-1:0]    w_vec [NUM_REQ];
    logic               w_last_wait;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_vec[i] = req_vec[i*IN_W +: IN_W];
        end
    end

    assign w_last_wait = (r_wait_cnt == CNT_W'(1));

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any)   w_state_nxt = WAIT;
            WAIT:    if (w_last_wait) w_state_nxt = RESP;
            RESP:    if (rsp_ready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_rr_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_core_in   <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt_any) begin
                    r_core_in  <= w_vec[w_gnt_idx];
                    r_rsp_id   <= w_gnt_idx;
                    r_wait_cnt <= CNT_W'(CORE_LAT);
                    r_rr_ptr   <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    if (w_last_wait) r_rsp_data <= core_out;
                end
                // Core input returns to zero between transactions so idle cycles see a known vector.
                RESP: if (rsp_ready) begin
                    r_txn_count <= r_txn_count + 16'd1;
                    r_core_in   <= '0;
                end
                default: ;
            endcase
        end
    end

    // A grant only counts in IDLE and never while reset is asserted.
    assign req_ready = (r_state == IDLE && blif_reset_net) ? w_grant : '0;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign core_in   = r_core_in;
    assign txn_count = r_txn_count;

endmodule

// File: doc/pattern_core_scheduler.md
# pattern_core_scheduler

Shares one merged-pattern datapath core (11-bit primary input vector, 11-bit registered output vector, fixed register latency) among several requesters. The block round-robin arbitrates request vectors, launches one vector at a time into the core, holds it stable for the core's latency, captures the core outputs and returns them with the winning requester's ID. It sits between the request fabric and a single instance of the pattern core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IN_W, 11, core primary-input width
- OUT_W, 11, core output width
- CORE_LAT, 2, clock edges from stable core input to valid core output (1..7)

- blif_clk_net  input  1  single clock, all flops rising-edge
- blif_reset_net  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request
- req_vec  input  NUM_REQ*IN_W  request vectors, requester i at bits [i*IN_W +: IN_W]
- req_ready  output  NUM_REQ  one-hot acceptance, at most one bit high
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  OUT_W  captured core outputs
- rsp_id  output  $clog2(NUM_REQ)  requester index of the result
- core_in  output  IN_W  drives core primary inputs
- core_out  input  OUT_W  core outputs
- busy  output  1  high in any state other than IDLE
- txn_count  output  16  completed responses, wraps 0xFFFF -> 0

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, the arbiter grants the first set bit at or after rr_ptr (cyclic); req_ready[g]=1 combinationally in that cycle; at the edge, core_in <= req_vec[g], rsp_id <= g, wait_cnt <= CORE_LAT, rr_ptr <= (g+1) mod NUM_REQ, go to WAIT. No req_valid: stay, req_ready all 0.
- WAIT: wait_cnt decrements each edge; on the edge where wait_cnt==1, rsp_data <= core_out, go to RESP. core_in held constant throughout.
- RESP: rsp_valid=1; rsp_data/rsp_id stable. On the edge with rsp_ready=1: txn_count++, core_in <= 0, go to IDLE. rsp_ready=0 stalls indefinitely; no new grants.
- req_ready is 0 outside IDLE; requester deasserting req_valid while not granted is legal and loses nothing.
- wait_cnt width $clog2(CORE_LAT+1); unsigned.
- rr_ptr only advances on a grant.

## Timing
- Reset (async assert, sync to clock by flops on deassert): state=IDLE, rr_ptr=0, wait_cnt=0, core_in=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0, txn_count=0.
- Accept edge E0 -> rsp_valid high after edge E0+CORE_LAT; core_out sampled at that edge, i.e. CORE_LAT edges after core_in became stable.
- With rsp_ready tied high, accept-to-accept spacing is CORE_LAT+2 cycles.
- Reset mid-WAIT or mid-RESP: transaction discarded, no response, txn_count cleared.
- All requesters valid continuously: grants rotate 0,1,2,3,0,...
- rsp_ready high in IDLE/WAIT: ignored.

## Structure
- Package pattern_sched_pkg: state enum (IDLE, WAIT, RESP), default width/latency constants, index-width helper.
- Sub-module rr_arbiter: combinational round-robin grant from req_valid and rr_ptr, outputs one-hot grant and encoded index; FSM and pointer register live in the top.

## Test plan
- Reset: hold blif_reset_net=0 with req_valid=4'b1111 -> all outputs 0, req_ready=0; release -> first grant to requester 0.
- Single request: req_valid=4'b0100, vec 11'h5A3, core model = 2-stage pipe of ~in -> rsp_valid after 2 edges, rsp_data=11'h25C, rsp_id=2, txn_count=1.
- Fairness: req_valid=4'b1111 for 8 transactions, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3; spacing 4 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data, rsp_id, core_in stable; req_ready stays 0; completes on rsp_ready=1.
- Reset mid-WAIT: assert reset one cycle after grant -> no rsp_valid, rr_ptr=0, next grant restarts from requester 0.
- Wrap: preload txn_count to 0xFFFF (force) and complete one transaction -> txn_count=0.
